lifo_stack_ctrl: RTL and testbench
==================================

# lifo_stack_ctrl

Parametrised synchronous LIFO stack, the next generation of the team's 8×8 stack. It adds simultaneous push/pop (replace-top), an occupancy count, an almost-full threshold, a combinational peek of top-of-stack, a pop-valid strobe and optional sticky overflow/underflow error flags. It sits between a producer/consumer pair in the datapath, such as an expression evaluator or return-address buffer, on a single clock domain.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_WIDTH, 3, log2(DEPTH); must match DEPTH exactly
- AFULL_THRESH, DEPTH-1, count at or above which almost_full asserts; legal range 1..DEPTH

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk
- push  input  1  write data_in onto the stack
- pop  input  1  remove top entry into data_out
- data_in  input  WIDTH  push data
- data_out  output  WIDTH  registered popped word; holds until the next successful pop
- pop_valid  output  1  one-cycle pulse, asserted the cycle after a successful pop
- top  output  WIDTH  combinational peek at mem[count-1]; 0 when empty
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_THRESH
- err_clr  input  1  clears sticky error flags
- overflow  output  1  sticky flag for a push rejected while full
- underflow  output  1  sticky flag for a pop rejected while empty

## Operation
- Storage is mem[0..DEPTH-1], and count is the stack pointer. The next push slot is mem[count]; the top entry is mem[count-1].
- Actions per cycle, decided from sampled push, pop, full and empty:
  - push only, not full: mem[count] <= data_in; count +1.
  - push only, full: no state change; overflow sets.
  - pop only, not empty: data_out <= mem[count-1]; count −1; pop_valid pulses next cycle.
  - pop only, empty: no state change; data_out holds; underflow sets.
  - push+pop, not empty (including full): replace-top. data_out <= old mem[count-1], mem[count-1] <= data_in, count unchanged, pop_valid pulses. No error.
  - push+pop, empty: bypass. data_out <= data_in, count stays 0, pop_valid pulses. No error.
  - neither: hold.
- full, empty and almost_full are combinational decodes of count.
- count arithmetic is unsigned, ADDR_WIDTH+1 bits wide, and never wraps. The guards above make stepping below 0 or above DEPTH unreachable.
- Error flags: err_clr takes priority over a same-cycle set, so the flag reads 0 the following cycle.
- Reset (reset_n low at a clock edge): count=0, data_out=0, pop_valid=0, overflow=0, underflow=0. mem is not cleared. Reset overrides any push/pop in the same cycle, including mid-sequence.

## Timing
- One-cycle latency: pop sampled at edge N → data_out and pop_valid valid after edge N, for the cycle N→N+1.
- A push at edge N is visible on top and count after edge N.
- A push followed by a pop on the next cycle returns the pushed word. There is no bubble.
- Back-to-back pops each return successive entries; pop_valid stays high continuously.
- Flags update on the same edge as count. There are no combinational paths from push/pop to any output.

## Configuration
- Macro: LIFO_STACK_ERR_EN.
- Defined: overflow and underflow are sticky registers as described, and err_clr is functional.
- Undefined: the error registers are not built, overflow and underflow are tied to 0, and err_clr is ignored. Illegal push/pop is still silently rejected with no state change.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with push=1, data_in=8'hAA → count=0, empty=1, data_out=0, pop_valid=0.
- Fill and drain: push 10,20,…,80 → full=1, almost_full=1 from count=7. Then pop ×8 → data_out 80,70,…,10, pop_valid high 8 cycles, empty=1.
- Overflow: while full, push 8'd99 → count stays 8, top=80, overflow=1. Pulse err_clr → overflow=0 next cycle. With LIFO_STACK_ERR_EN undefined, overflow stays 0.
- Underflow: while empty, pop → data_out holds its last value, pop_valid=0, underflow=1, count=0.
- Simultaneous ops: stack holds 10,20 and push+pop with 33 → data_out=20, top=33, count=2. When empty, push+pop with 44 → data_out=44, count=0, pop_valid=1.
- Reset mid-operation: push 10,20,30, then assert reset_n=0 in the same cycle as pop → count=0, data_out=0, pop_valid=0. The next push of 5 gives top=5, count=1.

Source files
------------

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack with replace-top, bypass, occupancy count, almost-full and peek.
// Define LIFO_STACK_ERR_EN to build the sticky overflow/underflow flags.
module lifo_stack_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  pop_valid,
    output logic [WIDTH-1:0]      top,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_AFULL = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [ADDR_WIDTH-1:0] top_idx;
    logic                  ovf_set, unf_set;

    // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
    assign top_idx     = count_q[ADDR_WIDTH-1:0] - IDX_ONE;
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_AFULL);
    assign top         = empty ? '0 : mem[top_idx];
    assign count       = count_q;
    assign data_out    = data_out_q;
    assign pop_valid   = pop_valid_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        count_d     = count_q;
        data_out_d  = data_out_q;
        pop_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = count_q[ADDR_WIDTH-1:0];
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    data_out_d  = mem[top_idx];
                    count_d     = count_q - CNT_ONE;
                    pop_valid_d = 1'b1;
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (!empty) begin
                    data_out_d = mem[top_idx];
                    mem_we     = 1'b1;
                    mem_waddr  = top_idx;
                end else begin
                    data_out_d = data_in;
                end
            end
            default: ;
        endcase
    end

    // NOTE: storage has no reset; only the pointer is cleared, which hides stale words.
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            mem[mem_waddr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            count_q     <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef LIFO_STACK_ERR_EN
    logic overflow_q, underflow_q;

    // Clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | ovf_set;
            underflow_q <= underflow_q | unf_set;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr, ovf_set, unf_set};
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Scoreboarded bench for lifo_stack_ctrl: directed scenarios then random traffic
// against a queue-based stack model.
module tb_lifo_stack_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             pop_valid;
    logic [WIDTH-1:0] top;
    logic [AW:0]      count;
    logic             full, empty, almost_full, overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    lifo_stack_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AFULL_THRESH(DEPTH - 1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .pop_valid(pop_valid), .top(top), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop_valid pulse must match the oldest expected popped word.
    always @(negedge clk) begin
        if (pop_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop_valid", 32'(1), 32'(0));
            end else begin
                check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic rn, input logic p, input logic q,
                        input logic [WIDTH-1:0] d, input logic c);
        logic ovf_set, unf_set;
        @(negedge clk);
        reset_n = rn; push = p; pop = q; data_in = d; err_clr = c;
        @(posedge clk);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!rn) begin
            model.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            if (p && !q) begin
                if (model.size() < DEPTH) model.push_back(d);
                else ovf_set = 1'b1;
            end else if (!p && q) begin
                if (model.size() > 0) begin
                    m_dout = model.pop_back();
                    exp_q.push_back(m_dout);
                end else begin
                    unf_set = 1'b1;
                end
            end else if (p && q) begin
                if (model.size() > 0) begin
                    m_dout = model.pop_back();
                    model.push_back(d);
                end else begin
                    m_dout = d;
                end
                exp_q.push_back(m_dout);
            end
`ifdef LIFO_STACK_ERR_EN
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                m_ovf = m_ovf | ovf_set;
                m_unf = m_unf | unf_set;
            end
`endif
        end
        #1;
        check("count", 32'(count), 32'(model.size()));
        check("top", 32'(top), (model.size() > 0) ? 32'(model[model.size()-1]) : 32'(0));
        check("empty", 32'(empty), 32'(model.size() == 0));
        check("full", 32'(full), 32'(model.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(model.size() >= DEPTH - 1));
        check("data_out", 32'(data_out), 32'(m_dout));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(0, 1, 0, 8'hAA, 0);
        step(0, 1, 0, 8'hAA, 0);
        for (int i = 1; i <= 8; i++) step(1, 1, 0, 8'(i * 10), 0);
        step(1, 1, 0, 8'd99, 0);
        step(1, 0, 0, 8'd0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 8'd0, 0);
        step(1, 0, 1, 8'd0, 0);
        step(1, 0, 0, 8'd0, 1);
        step(1, 1, 0, 8'd10, 0);
        step(1, 1, 0, 8'd20, 0);
        step(1, 1, 1, 8'd33, 0);
        step(1, 0, 1, 8'd0, 0);
        step(1, 0, 1, 8'd0, 0);
        step(1, 1, 1, 8'd44, 0);
        step(1, 1, 0, 8'd10, 0);
        step(1, 1, 0, 8'd20, 0);
        step(1, 1, 0, 8'd30, 0);
        step(0, 0, 1, 8'd0, 0);
        step(1, 1, 0, 8'd5, 0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 9) == 0));
        end
        step(1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 8'd0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
